// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I execute-stage constants and types
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_ADDU = 4'd10;
  localparam logic [3:0] ALU_SUBU = 4'd11;
  typedef enum logic [2:0] {
    CLS_ALU_REG, CLS_ALU_IMM, CLS_LUI, CLS_AUIPC,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_MEM
  } cls_e;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: decode-side, forwarding and memory-side signals of the execute stage
interface exe_stage_if;
  import riscv_pkg::*;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            in_rd_we;
  cls_e            in_class;
  logic [3:0]      in_alu_op;
  logic [2:0]      in_funct3;
  logic            fwd_mem_we, fwd_wb_we;
  logic [4:0]      fwd_mem_rd, fwd_wb_rd;
  logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_result, out_store_data, out_redirect_pc;
  logic [4:0]      out_rd;
  logic            out_rd_we, out_redirect;
  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm, in_rd, in_rd_we,
           in_class, in_alu_op, in_funct3, fwd_mem_we, fwd_wb_we, fwd_mem_rd, fwd_wb_rd,
           fwd_mem_data, fwd_wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_result, out_store_data, out_rd, out_rd_we,
           out_redirect, out_redirect_pc
  );
  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm, in_rd, in_rd_we,
           in_class, in_alu_op, in_funct3, fwd_mem_we, fwd_wb_we, fwd_mem_rd, fwd_wb_rd,
           fwd_mem_data, fwd_wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_result, out_store_data, out_rd, out_rd_we,
           out_redirect, out_redirect_pc
  );
endinterface

// File: rtl/alu.sv
// alu: RV32I integer ALU with zero/sign/carry/overflow flags
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            sf,
  output logic            cf,
  output logic            of
);
  logic [XLEN:0] sum, diff;
  logic          sub_op;
  assign sum    = {1'b0, lhs} + {1'b0, rhs};
  assign diff   = {1'b0, lhs} - {1'b0, rhs};
  assign sub_op = (op == ALU_SUB) || (op == ALU_SUBU);
  // result select; carry on sub is the borrow, i.e. lhs < rhs unsigned
  always_comb begin
    result = sum[XLEN-1:0];
    case (op)
      ALU_SLL:           result = lhs << rhs[4:0];
      ALU_SLT:           result = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
      ALU_SLTU:          result = {{(XLEN-1){1'b0}}, lhs < rhs};
      ALU_XOR:           result = lhs ^ rhs;
      ALU_SRL:           result = lhs >> rhs[4:0];
      ALU_OR:            result = lhs | rhs;
      ALU_AND:           result = lhs & rhs;
      ALU_SUB, ALU_SUBU: result = diff[XLEN-1:0];
      ALU_SRA:           result = $signed(lhs) >>> rhs[4:0];
      default:           result = sum[XLEN-1:0];
    endcase
    zf = result == '0;
    sf = result[XLEN-1];
    cf = sub_op ? diff[XLEN] : sum[XLEN];
    of = sub_op ? (lhs[XLEN-1] ^ rhs[XLEN-1]) & (diff[XLEN-1] ^ lhs[XLEN-1])
                : ~(lhs[XLEN-1] ^ rhs[XLEN-1]) & (sum[XLEN-1] ^ lhs[XLEN-1]);
  end
endmodule

// File: rtl/exe_fwd_unit.sv
// exe_fwd_unit: operand bypass mux, MEM result beats WB result beats register file
module exe_fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            mem_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data
);
  assign data = (rs == 5'd0) ? '0 :
                (mem_we && mem_rd == rs) ? mem_data :
                (wb_we && wb_rd == rs) ? wb_data : rf_data;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: RV32I execute stage with forwarding, branch resolution and EX/MEM register
module exe_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  exe_stage_if.slave  bus
);
  logic [XLEN-1:0] rs1_val, rs2_val, lhs, rhs, alu_res, link, br_target, next_result, next_rpc;
  logic [3:0]      op;
  logic            zf, sf, cf, of, taken, is_jump, redirect_now, transfer;
  logic            redir_q, redirect_sent;
  exe_fwd_unit u_fwd1 (
    .rs(bus.in_rs1), .rf_data(bus.in_rs1_data),
    .mem_we(bus.fwd_mem_we), .mem_rd(bus.fwd_mem_rd), .mem_data(bus.fwd_mem_data),
    .wb_we(bus.fwd_wb_we), .wb_rd(bus.fwd_wb_rd), .wb_data(bus.fwd_wb_data),
    .data(rs1_val)
  );
  exe_fwd_unit u_fwd2 (
    .rs(bus.in_rs2), .rf_data(bus.in_rs2_data),
    .mem_we(bus.fwd_mem_we), .mem_rd(bus.fwd_mem_rd), .mem_data(bus.fwd_mem_data),
    .wb_we(bus.fwd_wb_we), .wb_rd(bus.fwd_wb_rd), .wb_data(bus.fwd_wb_data),
    .data(rs2_val)
  );
  // operand and opcode selection by instruction class; address-style classes default to rs1+imm
  always_comb begin
    lhs = rs1_val;
    rhs = bus.in_imm;
    op  = ALU_ADD;
    case (bus.in_class)
      CLS_ALU_REG: begin rhs = rs2_val; op = bus.in_alu_op; end
      CLS_ALU_IMM: op = bus.in_alu_op;
      CLS_LUI:     lhs = '0;
      CLS_AUIPC,
      CLS_JAL:     lhs = bus.in_pc;
      CLS_BRANCH:  begin rhs = rs2_val; op = ALU_SUB; end
      default:     ;
    endcase
  end
  alu u_alu (
    .lhs(lhs), .rhs(rhs), .op(op), .result(alu_res),
    .zf(zf), .sf(sf), .cf(cf), .of(of)
  );
  assign link      = bus.in_pc + 32'd4;
  assign br_target = bus.in_pc + bus.in_imm;
  assign taken = (bus.in_funct3 == F3_BEQ)  ? zf :
                 (bus.in_funct3 == F3_BNE)  ? !zf :
                 (bus.in_funct3 == F3_BLT)  ? sf ^ of :
                 (bus.in_funct3 == F3_BGE)  ? !(sf ^ of) :
                 (bus.in_funct3 == F3_BLTU) ? cf :
                 (bus.in_funct3 == F3_BGEU) ? !cf : 1'b0;
  assign is_jump      = (bus.in_class == CLS_JAL) || (bus.in_class == CLS_JALR);
  assign redirect_now = is_jump || (bus.in_class == CLS_BRANCH && taken);
  assign next_result  = is_jump ? link : alu_res;
  assign next_rpc     = (bus.in_class == CLS_JALR) ? {alu_res[XLEN-1:1], 1'b0} :
                        is_jump ? alu_res : br_target;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign transfer     = bus.in_valid && bus.in_ready;
  // the redirect pulse is suppressed once sent so a stalled EX/MEM entry redirects fetch only once
  assign bus.out_redirect = bus.out_valid && redir_q && !redirect_sent;
  // EX/MEM pipeline register; flush kills both the held and the incoming instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid       <= 1'b0;
      bus.out_pc          <= RESET_PC;
      bus.out_result      <= '0;
      bus.out_store_data  <= '0;
      bus.out_rd          <= '0;
      bus.out_rd_we       <= 1'b0;
      bus.out_redirect_pc <= '0;
      redir_q             <= 1'b0;
      redirect_sent       <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
      redir_q       <= 1'b0;
      redirect_sent <= 1'b0;
    end else if (transfer) begin
      bus.out_valid       <= 1'b1;
      bus.out_pc          <= bus.in_pc;
      bus.out_result      <= next_result;
      bus.out_store_data  <= rs2_val;
      bus.out_rd          <= bus.in_rd;
      bus.out_rd_we       <= bus.in_rd_we && bus.in_rd != 5'd0;
      bus.out_redirect_pc <= next_rpc;
      redir_q             <= redirect_now;
      redirect_sent       <= 1'b0;
    end else begin
      if (bus.out_ready) bus.out_valid <= 1'b0;
      if (bus.out_redirect) redirect_sent <= 1'b1;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed-vector check of the execute stage
module tb_exe_stage;
  import riscv_pkg::*;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  int   vectors = 0, miscompares = 0;
  exe_stage_if bus ();
  exe_stage #(.RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input cls_e c, input logic [3:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we);
    bus.in_class = c; bus.in_alu_op = op; bus.in_funct3 = f3; bus.in_pc = pc;
    bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_rd_we = we;
    bus.in_valid = 1'b1;
  endtask
  task automatic issue(input cls_e c, input logic [3:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we);
    drive(c, op, f3, pc, d1, d2, imm, rs1, rs2, rd, we);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.fwd_mem_we = 1'b0; bus.fwd_mem_rd = '0; bus.fwd_mem_data = '0;
    bus.fwd_wb_we = 1'b0; bus.fwd_wb_rd = '0; bus.fwd_wb_data = '0;
    drive(CLS_ALU_REG, ALU_ADD, 3'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_pc", bus.out_pc, RPC);
    check("rst_result", bus.out_result, 32'd0);
    check("rst_redirect", {31'b0, bus.out_redirect}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(CLS_ALU_IMM, ALU_ADD, 3'b0, 32'h10, 32'h55, '0, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1);
    check("addi_result", bus.out_result, 32'd5);
    check("addi_valid", {31'b0, bus.out_valid}, 32'd1);
    check("addi_rd_we", {31'b0, bus.out_rd_we}, 32'd1);
    bus.fwd_mem_we = 1'b1; bus.fwd_mem_rd = 5'd1; bus.fwd_mem_data = 32'd5;
    issue(CLS_ALU_REG, ALU_ADD, 3'b0, 32'h14, '0, '0, '0, 5'd1, 5'd1, 5'd2, 1'b1);
    check("fwd_mem", bus.out_result, 32'd10);
    bus.fwd_wb_we = 1'b1; bus.fwd_wb_rd = 5'd1; bus.fwd_wb_data = 32'd7;
    issue(CLS_ALU_REG, ALU_ADD, 3'b0, 32'h18, '0, '0, '0, 5'd1, 5'd1, 5'd2, 1'b1);
    check("fwd_mem_over_wb", bus.out_result, 32'd10);
    bus.fwd_mem_we = 1'b0;
    issue(CLS_ALU_REG, ALU_ADD, 3'b0, 32'h1c, '0, '0, '0, 5'd1, 5'd1, 5'd2, 1'b1);
    check("fwd_wb", bus.out_result, 32'd14);
    bus.fwd_wb_we = 1'b0;
    issue(CLS_BRANCH, ALU_ADD, F3_BLT, 32'h100, 32'hffff_ffff, 32'd1, 32'h20, 5'd3, 5'd4, 5'd0, 1'b0);
    check("blt_redirect", {31'b0, bus.out_redirect}, 32'd1);
    check("blt_target", bus.out_redirect_pc, 32'h120);
    check("blt_store_data", bus.out_store_data, 32'd1);
    @(posedge clk); #1;
    check("idle_redirect", {31'b0, bus.out_redirect}, 32'd0);
    check("idle_valid", {31'b0, bus.out_valid}, 32'd0);
    issue(CLS_BRANCH, ALU_ADD, F3_BLTU, 32'h100, 32'hffff_ffff, 32'd1, 32'h20, 5'd3, 5'd4, 5'd0, 1'b0);
    check("bltu_redirect", {31'b0, bus.out_redirect}, 32'd0);
    check("bltu_valid", {31'b0, bus.out_valid}, 32'd1);
    issue(CLS_BRANCH, ALU_ADD, F3_BEQ, 32'h100, 32'h7fff_ffff, 32'h7fff_ffff, 32'h20, 5'd3, 5'd4, 5'd0, 1'b0);
    check("beq_redirect", {31'b0, bus.out_redirect}, 32'd1);
    check("beq_target", bus.out_redirect_pc, 32'h120);
    issue(CLS_JALR, ALU_ADD, 3'b0, 32'h200, 32'h1001, '0, 32'd4, 5'd5, 5'd0, 5'd1, 1'b1);
    check("jalr_target", bus.out_redirect_pc, 32'h1004);
    check("jalr_link", bus.out_result, 32'h204);
    check("jalr_rd_we", {31'b0, bus.out_rd_we}, 32'd1);
    check("jalr_redirect", {31'b0, bus.out_redirect}, 32'd1);
    issue(CLS_JAL, ALU_ADD, 3'b0, 32'hffff_fffc, '0, '0, 32'd8, 5'd0, 5'd0, 5'd1, 1'b1);
    check("jal_wrap_target", bus.out_redirect_pc, 32'h4);
    check("jal_wrap_link", bus.out_result, 32'h0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(CLS_BRANCH, ALU_ADD, F3_BGE, 32'h300, 32'd5, 32'd3, 32'hffff_fff0, 5'd6, 5'd7, 5'd0, 1'b0);
    check("stall_redirect_first", {31'b0, bus.out_redirect}, 32'd1);
    check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
    drive(CLS_ALU_IMM, ALU_ADD, 3'b0, 32'h304, '0, '0, 32'h42, 5'd0, 5'd0, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_redirect_held", {31'b0, bus.out_redirect}, 32'd0);
      check("stall_in_ready_held", {31'b0, bus.in_ready}, 32'd0);
      check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      check("stall_pc", bus.out_pc, 32'h300);
      check("stall_target", bus.out_redirect_pc, 32'h2f0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("after_stall_result", bus.out_result, 32'h42);
    check("after_stall_rd", {27'b0, bus.out_rd}, 32'd9);
    check("after_stall_redirect", {31'b0, bus.out_redirect}, 32'd0);
    drive(CLS_JAL, ALU_ADD, 3'b0, 32'h400, '0, '0, 32'h40, 5'd0, 5'd0, 5'd1, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    check("flush_redirect", {31'b0, bus.out_redirect}, 32'd0);
    issue(CLS_ALU_IMM, ALU_ADD, 3'b0, 32'h500, '0, '0, 32'd3, 5'd0, 5'd0, 5'd0, 1'b1);
    check("x0_rd_we", {31'b0, bus.out_rd_we}, 32'd0);
    check("x0_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(CLS_BRANCH, ALU_ADD, F3_BNE, 32'h600, 32'd1, 32'd2, 32'h8, 5'd1, 5'd2, 5'd0, 1'b0);
    check("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("async_rst_redirect", {31'b0, bus.out_redirect}, 32'd0);
    check("async_rst_pc", bus.out_pc, RPC);
    check("async_rst_target", bus.out_redirect_pc, 32'd0);
    check("async_rst_result", bus.out_result, 32'd0);
    #10 rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the RV32I pipeline. Sits between the decode stage (upstream) and the memory stage (downstream).
- Takes decoded instruction fields and register operands, and resolves operand forwarding from the MEM and WB stages.
- Drives one ALU instance, resolves branches and jumps from the ALU result and flags, and holds the EX/MEM pipeline register behind a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, value loaded into out_pc at reset

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill the instruction held in EX/MEM and the one accepted this cycle
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept an instruction this cycle
in_pc  in  XLEN  instruction PC
in_rs1, in_rs2  in  5 each  source register indices
in_rs1_data, in_rs2_data  in  XLEN each  register-file read data
in_imm  in  XLEN  sign-extended immediate
in_rd  in  5  destination register index
in_rd_we  in  1  instruction writes rd
in_class  in  3  instruction class: 0 ALU-reg, 1 ALU-imm, 2 LUI, 3 AUIPC, 4 BRANCH, 5 JAL, 6 JALR, 7 LOAD/STORE address
in_alu_op  in  4  ALU opcode (0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 or, 7 and, 8 sub, 9 sra, 10 addu, 11 subu)
in_funct3  in  3  branch condition select
fwd_mem_we, fwd_wb_we  in  1 each  forwarding source writes a register
fwd_mem_rd, fwd_wb_rd  in  5 each  forwarding destination index
fwd_mem_data, fwd_wb_data  in  XLEN each  forwarding data
out_valid  out  1  EX/MEM register holds a live instruction
out_ready  in  1  memory stage accepts
out_pc  out  XLEN  registered PC
out_result  out  XLEN  ALU result, or link address for JAL/JALR
out_store_data  out  XLEN  forwarded rs2 value
out_rd  out  5  registered rd
out_rd_we  out  1  registered write enable, forced 0 when rd==0
out_redirect  out  1  one-cycle pulse: fetch must redirect
out_redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_redirect=0, out_rd_we=0.
  - out_result=0, out_store_data=0, out_rd=0, out_redirect_pc=0, out_pc=RESET_PC.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Transfer occurs when in_valid && in_ready. EX/MEM loads on transfer; out_valid=1 the next cycle.
  - If out_ready && !transfer, out_valid clears.
  - If out_valid && !out_ready, the register and all outputs hold stable.
- Forwarding, per source operand, combinational, in priority order:
  - MEM match: fwd_mem_we && fwd_mem_rd==rs && rs!=0 → use fwd_mem_data.
  - WB match: same test on the WB fields → use fwd_wb_data.
  - Otherwise use the register-file data.
  - Index 0 always reads 0.
- ALU operand mux:
  - ALU-reg: lhs=rs1, rhs=rs2, op=in_alu_op.
  - ALU-imm: lhs=rs1, rhs=imm, op=in_alu_op.
  - LUI: lhs=0, rhs=imm, add.
  - AUIPC: lhs=pc, rhs=imm, add.
  - LOAD/STORE: lhs=rs1, rhs=imm, add.
  - BRANCH: lhs=rs1, rhs=rs2, sub.
  - JAL: lhs=pc, rhs=imm, add.
  - JALR: lhs=rs1, rhs=imm, add; result bit0 cleared.
- ALU flag contract on sub: ZF = result==0; SF = result[31]; CF=1 iff lhs<rhs unsigned; OF = signed overflow.
- Branch taken, by funct3:
  - 000 beq: ZF
  - 001 bne: !ZF
  - 100 blt: SF^OF
  - 101 bge: !(SF^OF)
  - 110 bltu: CF
  - 111 bgeu: !CF
  - 010 and 011: not taken
- Redirect:
  - Taken branch: target pc+imm, computed by a dedicated adder.
  - JAL/JALR: target = ALU result; out_result = pc+4.
- out_redirect is registered alongside the EX/MEM register. It is high for exactly one cycle per accepted redirecting instruction, even if out_ready stalls.
  - Implementation: a redirect_sent flag, set on the pulse and cleared on the next transfer.
- Flush:
  - Synchronous. Next cycle out_valid=0 and out_redirect=0. Any transfer in the same cycle is discarded.
  - flush dominates a simultaneous transfer and out_ready.
- Wrap-around: pc+4 and pc+imm wrap modulo 2^32 with no fault.
- Misaligned redirect target is passed through unchanged; alignment exceptions are out of scope.
- Latency: 1 cycle from accept to out_valid.

Decomposition:
- Package riscv_pkg holds:
  - ALU opcode constants (ALU_ADD..ALU_SUBU).
  - Instruction class enum (CLS_*).
  - Branch funct3 constants.
  - XLEN.
- One sub-module, exe_fwd_unit: combinational forwarding mux, instantiated twice (rs1, rs2).
- The ALU is instantiated as-is.

Test Plan:
- Back-to-back ALU ops:
  - addi x1,x0,5 then add x2,x1,x1 with fwd_mem_rd=1, fwd_mem_data=5 → out_result=10.
  - MEM forwarding beats WB forwarding (WB data 7) → out_result still 10.
- Branch conditions, at pc=0x100, imm=0x20:
  - blt rs1=0xffff_ffff, rs2=1 → out_redirect=1, out_redirect_pc=0x120.
  - bltu with the same operands → not taken.
  - beq 0x7fff_ffff vs 0x7fff_ffff → taken.
- JALR: rs1=0x1001, imm=4, pc=0x200 → out_redirect_pc=0x1004, out_result=0x204, out_rd_we=1.
- Stall: out_ready=0 for 3 cycles after a taken branch → in_ready=0, outputs stable, out_redirect high exactly one cycle.
- Flush with simultaneous in_valid and out_ready=1 → next cycle out_valid=0, no redirect.
- Write to x0: rd=0 → out_rd_we=0.
- Reset asserted mid-stall → out_valid=0 immediately (async), outputs at their reset values.
